// File: rtl/mem_read_arbiter_pkg.sv
// mem_arb_pkg: shared FSM state type and default burst-length width for the read arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ADDR, ARB_DATA} arb_state_e;
  localparam int LEN_W = 4;
endpackage

// File: rtl/mem_read_arbiter_if.sv
// mem_read_arbiter_if: requester-side and memory-side AR/R signals of the read arbiter
interface mem_read_arbiter_if import mem_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = LEN_W
);
  logic [NUM_REQ-1:0]            req_arvalid;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_araddr;
  logic [NUM_REQ*LEN_WIDTH-1:0]  req_arlen;
  logic [NUM_REQ-1:0]            req_arready;
  logic [NUM_REQ-1:0]            req_rvalid;
  logic                          req_rlast;
  logic [DATA_WIDTH-1:0]         req_rdata;
  logic [NUM_REQ-1:0]            req_rready;
  logic                          mem_arvalid;
  logic [ADDR_WIDTH-1:0]         mem_araddr;
  logic [LEN_WIDTH-1:0]          mem_arlen;
  logic                          mem_arready;
  logic                          mem_rvalid;
  logic [DATA_WIDTH-1:0]         mem_rdata;
  logic                          mem_rlast;
  logic                          mem_rready;
  logic                          busy;
  logic                          len_err;
  modport master (
    input  req_arvalid, req_araddr, req_arlen, req_rready,
           mem_arready, mem_rvalid, mem_rdata, mem_rlast,
    output req_arready, req_rvalid, req_rlast, req_rdata,
           mem_arvalid, mem_araddr, mem_arlen, mem_rready, busy, len_err
  );
  modport slave (
    output req_arvalid, req_araddr, req_arlen, req_rready,
           mem_arready, mem_rvalid, mem_rdata, mem_rlast,
    input  req_arready, req_rvalid, req_rlast, req_rdata,
           mem_arvalid, mem_araddr, mem_arlen, mem_rready, busy, len_err
  );
endinterface

// File: rtl/mem_read_arbiter_rr_picker.sv
// rr_picker: first asserted request at or after rr_ptr, wrapping at NUM_REQ
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_ptr,
  output logic               valid,
  output logic [IW-1:0]      index
);
  // scan from the farthest offset down so the nearest hit to rr_ptr wins
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        valid = 1'b1;
        index = IW'((int'(rr_ptr) + i) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin sharing of one AR/R read port, grant held for a whole burst
module mem_read_arbiter import mem_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = LEN_W
) (
  input logic clk,
  input logic rst,
  mem_read_arbiter_if.master bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_e            state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d, owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [LEN_WIDTH-1:0]  arlen_q, arlen_d, beat_cnt_q, beat_cnt_d;
  logic                  len_err_q, len_err_d;
  logic                  pick_valid, beat;
  logic [IW-1:0]         pick_idx;
  logic [NUM_REQ-1:0]    owner_oh;
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (bus.req_arvalid),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );
  assign owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
  assign beat     = (state_q == ARB_DATA) && bus.mem_rvalid && bus.mem_rready;
  // next state: capture the picked request in IDLE, hold until AR accepted, count beats until rlast
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    beat_cnt_d = beat_cnt_q;
    len_err_d  = len_err_q;
    case (state_q)
      ARB_IDLE: if (pick_valid) begin
        state_d  = ARB_ADDR;
        owner_d  = pick_idx;
        araddr_d = bus.req_araddr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
        arlen_d  = bus.req_arlen[pick_idx*LEN_WIDTH +: LEN_WIDTH];
      end
      ARB_ADDR: if (bus.mem_arready) begin
        state_d    = ARB_DATA;
        beat_cnt_d = '0;
      end
      ARB_DATA: if (beat) begin
        beat_cnt_d = beat_cnt_q + 1'b1;
        len_err_d  = len_err_q | (bus.mem_rlast != (beat_cnt_q == arlen_q));
        if (bus.mem_rlast) begin
          state_d  = ARB_IDLE;
          rr_ptr_d = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end
  // arbiter state; async reset abandons any burst in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
    end
  end
  assign bus.mem_arvalid = state_q == ARB_ADDR;
  assign bus.mem_araddr  = araddr_q;
  assign bus.mem_arlen   = arlen_q;
  assign bus.req_arready = (state_q == ARB_ADDR && bus.mem_arready) ? owner_oh : '0;
  assign bus.mem_rready  = (state_q == ARB_DATA) && bus.req_rready[owner_q];
  assign bus.req_rvalid  = (state_q == ARB_DATA && bus.mem_rvalid) ? owner_oh : '0;
  assign bus.req_rlast   = (state_q == ARB_DATA) && bus.mem_rlast;
  assign bus.req_rdata   = (state_q == ARB_DATA) ? bus.mem_rdata : {DATA_WIDTH{1'b0}};
  assign bus.busy        = state_q != ARB_IDLE;
  assign bus.len_err     = len_err_q;
endmodule

// File: tb/tb_mem_read_arbiter.sv
// tb_mem_read_arbiter: vector table plus directed burst sequences for mem_read_arbiter
module tb_mem_read_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_read_arbiter_if bus ();
  mem_read_arbiter dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [3:0]  arv;
    logic        arrdy, rv, rl;
    logic [3:0]  rrdy;
    logic [31:0] rd;
    logic        earv;
    logic [25:0] eaddr;
    logic [3:0]  elen, earrdy, ervalid;
    logic        erl, emr, ebusy;
    logic [31:0] erd;
  } vec_t;
  vec_t vt [14];
  function automatic logic [25:0] addr_of(input int i);
    return 26'(i + 1) << 8;
  endfunction
  function automatic logic [3:0] len_of(input int i);
    return i == 0 ? 4'd3 : i == 1 ? 4'd1 : i == 2 ? 4'd2 : 4'd0;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_idle(input string nm);
    chk(nm, 128'({bus.mem_arvalid, bus.req_arready, bus.req_rvalid, bus.req_rlast, bus.mem_rready,
                  bus.busy, bus.len_err, bus.req_rdata, bus.mem_araddr, bus.mem_arlen}), 128'(0));
  endtask
  task automatic clear_inputs;
    bus.req_arvalid = '0;
    bus.req_rready  = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rlast   = 1'b0;
    bus.mem_rdata   = '0;
  endtask
  task automatic do_reset(input string nm);
    rst = 1'b1;
    clear_inputs();
    #1;
    check_idle(nm);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_ar(input string nm);
    int n = 0;
    while (bus.mem_arvalid !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 128'(bus.mem_arvalid), 128'(1));
  endtask
  task automatic serve(input int own, input int rlast_at, input bit exp_err, input bit keep);
    logic [31:0] d;
    wait_ar($sformatf("ar_seen_%0d", own));
    chk($sformatf("ar_addr_%0d", own), 128'({bus.mem_araddr, bus.mem_arlen}), 128'({addr_of(own), len_of(own)}));
    bus.mem_arready = 1'b1;
    #1;
    chk($sformatf("arready_%0d", own), 128'(bus.req_arready), 128'(4'b0001 << own));
    @(negedge clk);
    bus.mem_arready = 1'b0;
    if (!keep) bus.req_arvalid[own] = 1'b0;
    for (int b = 0; b <= rlast_at; b++) begin
      d = 32'hC0DE_0000 | 32'(own * 256 + b);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = d;
      bus.mem_rlast  = b == rlast_at;
      bus.req_rready = 4'hF;
      #1;
      chk($sformatf("beat_%0d_%0d", own, b), 128'({bus.req_rvalid, bus.req_rlast, bus.mem_rready, bus.req_rdata}),
          128'({4'b0001 << own, b == rlast_at, 1'b1, d}));
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    #1;
    chk($sformatf("end_%0d", own), 128'({bus.busy, bus.len_err}), 128'({1'b0, exp_err}));
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] got [$];
    logic [31:0] dpat [7];
    logic        rpat [7];
    vec_t v;
    for (int i = 0; i < 4; i++) begin
      bus.req_araddr[i*26 +: 26] = addr_of(i);
      bus.req_arlen[i*4 +: 4]    = len_of(i);
    end
    vt[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,       1'b0, 26'h000, 4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,       1'b1, 26'h100, 4'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[2]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,       1'b1, 26'h100, 4'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[3]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0,       1'b1, 26'h100, 4'd3, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[4]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h1111_0000, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h1111_0000};
    vt[5]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h1111_0001, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h1111_0001};
    vt[6]  = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'hF, 32'h1111_0002, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1, 32'h1111_0002};
    vt[7]  = '{4'b0000, 1'b0, 1'b1, 1'b1, 4'hF, 32'h1111_0003, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b1, 32'h1111_0003};
    vt[8]  = '{4'b0011, 1'b0, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[9]  = '{4'b0011, 1'b1, 1'b0, 1'b0, 4'hF, 32'h0,       1'b1, 26'h200, 4'd1, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    vt[10] = '{4'b0001, 1'b0, 1'b1, 1'b0, 4'b0010, 32'hA0, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1, 32'hA0};
    vt[11] = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0010, 32'hA1, 1'b0, 26'h000, 4'd0, 4'b0000, 4'b0010, 1'b1, 1'b1, 1'b1, 32'hA1};
    vt[12] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,       1'b0, 26'h000, 4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vt[13] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'hF, 32'h0,       1'b1, 26'h100, 4'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 32'h0};
    #3;
    do_reset("reset_state");
    for (int i = 0; i < 14; i++) begin
      v = vt[i];
      bus.req_arvalid = v.arv;
      bus.mem_arready = v.arrdy;
      bus.mem_rvalid  = v.rv;
      bus.mem_rlast   = v.rl;
      bus.req_rready  = v.rrdy;
      bus.mem_rdata   = v.rd;
      #1;
      chk($sformatf("vec%0d", i),
          128'({bus.mem_arvalid, bus.mem_arvalid ? {bus.mem_araddr, bus.mem_arlen} : 30'h0, bus.req_arready,
                bus.req_rvalid, bus.req_rlast, bus.mem_rready, bus.busy, bus.req_rdata}),
          128'({v.earv, v.earv ? {v.eaddr, v.elen} : 30'h0, v.earrdy, v.ervalid, v.erl, v.emr, v.ebusy, v.erd}));
      @(negedge clk);
    end
    do_reset("reset_after_table");
    bus.req_arvalid = 4'hF;
    serve(0, 3, 1'b0, 1'b1);
    serve(1, 1, 1'b0, 1'b1);
    serve(2, 2, 1'b0, 1'b1);
    serve(3, 0, 1'b0, 1'b1);
    serve(0, 3, 1'b0, 1'b1);
    do_reset("reset_after_rotation");
    bus.req_arvalid = 4'b0100;
    serve(2, 2, 1'b0, 1'b0);
    bus.req_arvalid = 4'b1010;
    serve(3, 0, 1'b0, 1'b0);
    bus.req_arvalid = bus.req_arvalid | 4'b0001;
    serve(0, 3, 1'b0, 1'b0);
    serve(1, 1, 1'b0, 1'b0);
    bus.req_arvalid = 4'b0001;
    wait_ar("stall_ar");
    bus.mem_arready = 1'b1;
    @(negedge clk);
    bus.mem_arready = 1'b0;
    bus.req_arvalid = '0;
    rpat = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    dpat = '{32'hD0, 32'hD1, 32'hD1, 32'hD1, 32'hD1, 32'hD2, 32'hD3};
    for (int i = 0; i < 7; i++) begin
      bus.req_rready = {3'b000, rpat[i]};
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = dpat[i];
      bus.mem_rlast  = i == 6;
      #1;
      chk($sformatf("stall_rready%0d", i), 128'(bus.mem_rready), 128'(rpat[i]));
      if (bus.req_rvalid[0] && bus.mem_rready) got.push_back(bus.req_rdata);
      @(negedge clk);
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rlast  = 1'b0;
    #1;
    chk("stall_beats", 128'(got.size()), 128'(4));
    for (int k = 0; k < 4 && k < got.size(); k++)
      chk($sformatf("stall_data%0d", k), 128'(got[k]), 128'(32'hD0 + 32'(k)));
    chk("stall_end", 128'({bus.busy, bus.len_err}), 128'(0));
    bus.req_arvalid = 4'b0001;
    serve(0, 2, 1'b1, 1'b0);
    bus.req_arvalid = 4'b0001;
    serve(0, 3, 1'b1, 1'b0);
    bus.req_arvalid = 4'b0001;
    wait_ar("rst_ar");
    bus.mem_arready = 1'b1;
    @(negedge clk);
    bus.mem_arready = 1'b0;
    bus.req_arvalid = '0;
    bus.req_rready  = 4'hF;
    for (int b = 0; b < 2; b++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hE0 + 32'(b);
      @(negedge clk);
    end
    bus.mem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("rst_mid_pre", 128'({bus.busy, bus.req_rvalid, bus.req_rdata}), 128'({1'b1, 4'b0001, 32'hBAD0_BAD0}));
    #1;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    bus.req_arvalid = 4'b0100;
    serve(2, 2, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
